mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential signed multiplier (W x W -> 2W, one-cycle load pulse, fixed latency)
//  between two requesters. Requester transfers use a valid/ready handshake. Grants are
//  round-robin. The block pulses the multiplier load, waits MULT_LAT cycles, then returns
//  the 2W product tagged with the requester id.
// PARAMETERS
//  W         16  operand width; the product is 2W bits, signed two's complement
//  MULT_LAT  16  cycles from the multiplier load pulse to a valid mul_o (must be >= 1)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  req0_valid  in   1   requester 0 holds an operand pair
//  req0_x      in   W   requester 0 multiplicand (signed)
//  req0_y      in   W   requester 0 multiplier (signed)
//  req0_ready  out  1   requester 0 operands accepted this cycle
//  req1_valid  in   1   requester 1 holds an operand pair
//  req1_x      in   W   requester 1 multiplicand (signed)
//  req1_y      in   W   requester 1 multiplier (signed)
//  req1_ready  out  1   requester 1 operands accepted this cycle
//  rsp_valid   out  1   product available
//  rsp_id      out  1   requester that owns rsp_o
//  rsp_o       out  2W  signed product
//  rsp_ready   in   1   consumer takes the product
//  mul_x       out  W   multiplier operand X (registered)
//  mul_y       out  W   multiplier operand Y (registered)
//  mul_l       out  1   multiplier load pulse
//  mul_o       in   2W  multiplier result
// BEHAVIOUR
//  - States: IDLE, LOAD, BUSY, RESP. Encoding is binary.
//  - Reset (async, rst_n=0):
//      state=IDLE; counter=0; last=1, so requester 0 wins the first tie.
//      mul_x, mul_y, mul_l, rsp_valid, rsp_id and rsp_o are all 0.
//  - IDLE:
//      Winner = the only valid requester. If both are valid, the winner is the one that is not `last`.
//      reqN_ready=1 combinationally for the winner only. reqN_ready is 0 in every other state.
//      On handshake (valid & ready): register the operands into mul_x/mul_y, register the id, go to LOAD.
//      A requester may drop valid without a handshake. This has no effect.
//  - LOAD: mul_l=1 for exactly this one cycle. Counter is cleared. Go to BUSY.
//  - BUSY:
//      Counter increments each cycle. mul_x/mul_y stay stable.
//      When counter==MULT_LAT-1: capture mul_o into rsp_o, update last to the id, go to RESP.
//  - RESP:
//      rsp_valid=1. rsp_o and rsp_id stay stable until rsp_ready=1.
//      On handshake: rsp_valid drops on the next edge and the state goes to IDLE.
//      There is no new grant in the RESP cycle.
//  - Latency: accept edge t -> mul_l high in cycle t+1 -> rsp_valid high from cycle t+2+MULT_LAT.
//    Minimum occupancy is MULT_LAT+3 cycles per operation.
//  - mul_l is 0 in every state except LOAD. Only one operation is ever in flight.
//  - Counter width is $clog2(MULT_LAT+1). There is no wrap-around inside an operation.
//  - Reset asserted mid-operation aborts it:
//      all outputs return to their reset values;
//      the multiplier's in-flight result is ignored;
//      the interrupted requester is not re-served automatically.
//  - The product is passed through unmodified. The arbiter performs no sign or width
//    manipulation beyond the 2W capture.
// STRUCTURE
//  - Shared header mult_arb_defs.vh holds:
//      state localparams S_IDLE/S_LOAD/S_BUSY/S_RESP;
//      default W and MULT_LAT.
//  - Sub-module rr_arb2 (combinational): inputs v0, v1, last; outputs gnt0, gnt1.
//  - The FSM, counter and registers live in mult_arbiter.
// TESTING (bench pairs the arbiter with the multiplier; MULT_LAT matches the multiplier)
//  1. req0 only, X=11111, Y=3
//       -> req0_ready for 1 cycle, mul_l 1 cycle later;
//          rsp_valid at t+2+MULT_LAT with rsp_o=33333, rsp_id=0.
//  2. req0 and req1 valid together after reset, req0 {-7,9}, req1 {-32768,-32768}
//       -> first response id=0, rsp_o=-63;
//          second response id=1, rsp_o=1073741824.
//  3. req1 held valid for 3 back-to-back ops with Y=0,1,2, X=11111
//       -> products 0, 11111, 22222;
//          req1_ready is never high outside IDLE.
//  4. rsp_ready held low for 5 cycles during RESP
//       -> rsp_o and rsp_id stable, rsp_valid stays 1;
//          no reqN_ready while a request is pending.
//  5. rst_n pulsed low mid-BUSY
//       -> all outputs 0 immediately;
//          the next request, {100,-5}, returns -500 with correct latency and id.
//  6. Alternating contention, both always valid
//       -> ids alternate 0,1,0,1 and mul_l pulses exactly once per op.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   - default operand width and multiplier latency
//   - binary-encoded FSM state type
package mult_arbiter_pkg;

    localparam int W_DEF        = 16;
    localparam int MULT_LAT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mult_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   v0, v1 : request valids
//   last   : id served most recently; the other requester wins a tie
//   gnt0/1 : one-hot (or zero) grant
module rr_arb2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = v0 & (~v1 |  last);
    assign gnt1 = v1 & (~v0 | ~last);

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one fixed-latency sequential signed multiplier between
// two valid/ready requesters with round-robin grants.
//   clk, rst_n                : clock, async active-low reset
//   reqN_valid/x/y/ready      : requester N operand handshake (N = 0, 1)
//   rsp_valid/id/o, rsp_ready : tagged 2W product handshake to the consumer
//   mul_x/mul_y/mul_l         : registered operands and one-cycle load pulse
//   mul_o                     : multiplier result, valid MULT_LAT cycles after load
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic           req1_ready,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_o,
    input  logic           rsp_ready,
    output logic [W-1:0]   mul_x,
    output logic [W-1:0]   mul_y,
    output logic           mul_l,
    input  logic [2*W-1:0] mul_o
);

    localparam int             CW       = $clog2(MULT_LAT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MULT_LAT - 1);

    state_t          r_state;
    state_t          w_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_last;
    logic            r_id;
    logic [W-1:0]    r_mul_x;
    logic [W-1:0]    r_mul_y;
    logic [2*W-1:0]  r_rsp_o;

    logic w_gnt0, w_gnt1;
    logic w_hs0, w_hs1;
    logic w_done;

    rr_arb2 u_rr (
        .v0   (req0_valid),
        .v1   (req1_valid),
        .last (r_last),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    // Grants are only exposed while idle, so nothing is accepted mid-operation.
    assign req0_ready = (r_state == S_IDLE) & w_gnt0;
    assign req1_ready = (r_state == S_IDLE) & w_gnt1;
    assign w_hs0      = req0_valid & req0_ready;
    assign w_hs1      = req1_valid & req1_ready;
    assign w_done     = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

    assign mul_l     = (r_state == S_LOAD);
    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_o     = r_rsp_o;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_hs0 | w_hs1) w_nxt = S_LOAD;
            S_LOAD: w_nxt = S_BUSY;
            S_BUSY: if (w_done) w_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_mul_x <= '0;
            r_mul_y <= '0;
            r_rsp_o <= '0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_hs0 | w_hs1) begin
                        r_mul_x <= w_hs1 ? req1_x : req0_x;
                        r_mul_y <= w_hs1 ? req1_y : req0_y;
                        r_id    <= w_hs1;
                    end
                end
                S_LOAD: r_cnt <= '0;
                S_BUSY: begin
                    // Final increment reaches MULT_LAT, which still fits in CW bits.
                    r_cnt <= r_cnt + CW'(1);
                    if (w_done) begin
                        r_rsp_o <= mul_o;
                        r_last  <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int W = 16;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]   req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic           req0_ready, req1_ready;
    logic           rsp_valid, rsp_id;
    logic [2*W-1:0] rsp_o;
    logic           rsp_ready = 1'b1;
    logic [W-1:0]   mul_x, mul_y;
    logic           mul_l;
    logic [2*W-1:0] mul_o;

    always #5 clk = ~clk;

    mult_arbiter #(.W(W), .MULT_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_o(rsp_o), .rsp_ready(rsp_ready),
        .mul_x(mul_x), .mul_y(mul_y), .mul_l(mul_l), .mul_o(mul_o)
    );

    // Multiplier model: result valid only in the L-th cycle after the load
    // cycle; a junk pattern otherwise so an early/late capture shows up.
    logic [2*W-1:0] m_p = '0;
    int             m_rem = 0;
    always @(posedge clk) begin
        if (mul_l) begin
            m_p   <= $signed(mul_x) * $signed(mul_y);
            m_rem <= L;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
        end
    end
    assign mul_o = (m_rem == 1) ? m_p : {(2*W/16){16'hBAD0}};

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one transaction outstanding at a time, round-robin
    // preference, fixed response time after acceptance.
    int             cyc = 0;
    always @(posedge clk) cyc++;

    bit             busy = 0, last_m = 1, b0;
    int             acc_cyc = 0;
    logic           id_m = 0;
    logic [W-1:0]   x_m = '0, y_m = '0;
    logic [2*W-1:0] p_m = '0;
    int             n_acc = 0, n_mull = 0;
    logic [2*W-1:0] log_p[$];
    logic           log_id[$];
    logic           e0, e1, erv, hs0, hs1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mul_l", mul_l, 0);
            chk("rst_mul_x", mul_x, 0);
            chk("rst_mul_y", mul_y, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_o", rsp_o, 0);
            busy = 0;
            last_m = 1;
        end else begin
            b0 = busy;
            e0 = !busy && req0_valid && (!req1_valid || last_m);
            e1 = !busy && req1_valid && (!req0_valid || !last_m);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("mul_l", mul_l, busy && (cyc == acc_cyc + 1));
            if (mul_l) n_mull++;
            erv = busy && (cyc >= acc_cyc + 2 + L);
            chk("rsp_valid", rsp_valid, erv);
            if (busy && cyc > acc_cyc) begin
                chk("mul_x", mul_x, x_m);
                chk("mul_y", mul_y, y_m);
            end
            if (erv) begin
                chk("rsp_o", rsp_o, p_m);
                chk("rsp_id", rsp_id, id_m);
                if (rsp_ready) begin
                    log_p.push_back(p_m);
                    log_id.push_back(id_m);
                    busy = 0;
                end
            end
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (!b0 && (hs0 || hs1)) begin
                id_m    = hs1;
                x_m     = hs1 ? req1_x : req0_x;
                y_m     = hs1 ? req1_y : req0_y;
                p_m     = $signed(x_m) * $signed(y_m);
                last_m  = id_m;
                acc_cyc = cyc;
                busy    = 1;
                n_acc++;
            end
        end
    end

    task automatic wait_hs(input int id);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if ((id == 0 && req0_valid && req0_ready) || (id == 1 && req1_valid && req1_ready))
                ok = 1;
        end
        if (!ok) chk("hs_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #2;
            if (!busy) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic op(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
        if (id == 0) begin req0_x = x; req0_y = y; req0_valid = 1; end
        else         begin req1_x = x; req1_y = y; req1_valid = 1; end
        wait_hs(id);
        req0_valid = 0; req1_valid = 0;
        wait_idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    int n, m0, bok;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // 1: single requester
        op(0, 16'd11111, 16'd3);
        n = log_p.size();
        chk("t1_p", log_p[n-1], 32'd33333);
        chk("t1_id", log_id[n-1], 0);

        // 2: simultaneous requests after reset, req0 wins the first tie
        do_reset();
        req0_x = -16'sd7; req0_y = 16'sd9; req1_x = 16'h8000; req1_y = 16'h8000;
        req0_valid = 1; req1_valid = 1;
        wait_hs(0); req0_valid = 0;
        wait_hs(1); req1_valid = 0;
        wait_idle();
        n = log_p.size();
        chk("t2_id0", log_id[n-2], 0);
        chk("t2_p0", log_p[n-2], 32'hFFFF_FFC1);
        chk("t2_id1", log_id[n-1], 1);
        chk("t2_p1", log_p[n-1], 32'h4000_0000);

        // 3: back-to-back from req1 with valid held
        req1_x = 16'd11111; req1_y = 16'd0; req1_valid = 1;
        wait_hs(1); req1_y = 16'd1;
        wait_hs(1); req1_y = 16'd2;
        wait_hs(1); req1_valid = 0;
        wait_idle();
        n = log_p.size();
        chk("t3_p0", log_p[n-3], 32'd0);
        chk("t3_p1", log_p[n-2], 32'd11111);
        chk("t3_p2", log_p[n-1], 32'd22222);

        // 4: consumer stalls the response while another request waits
        rsp_ready = 0;
        req1_x = -16'sd300; req1_y = 16'sd77; req1_valid = 1;
        wait_hs(1); req1_valid = 0;
        req0_x = 16'd5; req0_y = 16'd6; req0_valid = 1;
        bok = 0;
        for (int i = 0; i < 100 && !bok; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) bok = 1;
        end
        if (!bok) chk("t4_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_valid", rsp_valid, 1);
        chk("t4_p", rsp_o, 32'(-23100));
        chk("t4_id", rsp_id, 1);
        chk("t4_no_rdy0", req0_ready, 0);
        rsp_ready = 1;
        wait_hs(0); req0_valid = 0;
        wait_idle();
        chk("t4_p2", log_p[log_p.size()-1], 32'd30);

        // 5: reset mid-operation
        req0_x = 16'd1234; req0_y = 16'd5; req0_valid = 1;
        wait_hs(0); req0_valid = 0;
        repeat (6) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t5_mul_x", mul_x, 0);
        chk("t5_mul_y", mul_y, 0);
        chk("t5_mul_l", mul_l, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_o", rsp_o, 0);
        chk("t5_rsp_id", rsp_id, 0);
        @(posedge clk); #1 rst_n = 1;
        n = log_p.size();
        op(1, 16'd100, -16'sd5);
        chk("t5_count", log_p.size(), n + 1);
        chk("t5_p", log_p[log_p.size()-1], 32'(-500));
        chk("t5_id", log_id[log_id.size()-1], 1);

        // 6: permanent contention alternates
        m0 = n_mull;
        n  = log_p.size();
        req0_x = 16'($urandom); req0_y = 16'($urandom);
        req1_x = 16'($urandom); req1_y = 16'($urandom);
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            wait_hs(k % 2);
            if (k % 2 == 0) begin req0_x = 16'($urandom); req0_y = 16'($urandom); end
            else            begin req1_x = 16'($urandom); req1_y = 16'($urandom); end
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        for (int k = 0; k < 4; k++) chk("t6_id", log_id[n+k], k % 2);
        chk("t6_mul_l_pulses", n_mull - m0, 4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_x = 16'($urandom); req0_y = 16'($urandom);
            req1_x = 16'($urandom); req1_y = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        wait_idle();
        chk("mul_l_per_op", n_mull, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
